// File: rtl/camera_sensor_emulator_if.sv
// rtl/camera_sensor_emulator_if.sv - sensor-side signal bundle of the camera emulator
// The master modport is the emulator; the slave side requests the run and consumes the pixel stream.
interface camera_sensor_emulator_if;
  logic        Enable;
  logic        oPIXCLK;
  logic        oFrame_Valid;
  logic        oLine_Valid;
  logic [9:0]  oCamera_Data;
  logic [31:0] oFrame_Count;
  logic        oBusy;

  modport master (
    input  Enable,
    output oPIXCLK, oFrame_Valid, oLine_Valid, oCamera_Data, oFrame_Count, oBusy
  );

  modport slave (
    output Enable,
    input  oPIXCLK, oFrame_Valid, oLine_Valid, oCamera_Data, oFrame_Count, oBusy
  );
endinterface

// File: rtl/camera_sensor_emulator.sv
// rtl/camera_sensor_emulator.sv - FVAL/LVAL/PIXCLK camera sensor emulator with Bayer bar pattern
// Define CAMERA_EMU_RAMP_EN for a per-pixel ramp instead of the colour bars; timing is identical.
module camera_sensor_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 32,
  parameter int V_BLANK  = 8
) (
  input logic                       Clock,
  input logic                       Resetn,
  camera_sensor_emulator_if.master  cam
);
  localparam int VB_PIX = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int BW     = $clog2(VB_PIX);
  localparam int XW     = $clog2(H_ACTIVE);
  localparam int YW     = $clog2(V_ACTIVE);
  localparam logic [BW-1:0] VB_LAST = BW'(VB_PIX - 1);
  localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_VBLANK, ST_HLEAD, ST_ACTIVE, ST_HTAIL} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   cnt, cnt_n;
  logic [XW-1:0]   x, x_n;
  logic [YW-1:0]   y, y_n;
  logic            pixclk, fval, lval, fval_n, frame_done;
  logic [9:0]      data, data_n;
  logic [31:0]     frame_count;

  // pixclk is only ever high outside IDLE, so its high phase marks the pixel boundary edge
  logic tick;
  assign tick = pixclk;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
      y     <= y_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    x_n        = x;
    y_n        = y;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cam.Enable) begin
          state_n = ST_VBLANK;
          cnt_n   = '0;
        end
      end
      ST_VBLANK: begin
        if (tick) begin
          if (!cam.Enable) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (cnt == VB_LAST) begin
            state_n = ST_HLEAD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_HLEAD: begin
        if (tick) begin
          if (cnt == HB_LAST) begin
            state_n = ST_ACTIVE;
            cnt_n   = '0;
            x_n     = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (tick) begin
          if (x == X_LAST) begin
            state_n    = ST_HTAIL;
            cnt_n      = '0;
            frame_done = (y == Y_LAST);
          end else begin
            x_n = x + 1'b1;
          end
        end
      end
      ST_HTAIL: begin
        if (tick) begin
          if (cnt != HB_LAST) begin
            cnt_n = cnt + 1'b1;
          end else if (y != Y_LAST) begin
            state_n = ST_ACTIVE;
            cnt_n   = '0;
            x_n     = '0;
            y_n     = y + 1'b1;
          end else begin
            // Enable is honoured only here and in V_BLANK so a frame is never cut short
            state_n = cam.Enable ? ST_VBLANK : ST_IDLE;
            cnt_n   = '0;
            x_n     = '0;
            y_n     = '0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef CAMERA_EMU_RAMP_EN
  always_comb begin
    data_n = 10'h000;
    if (state_n == ST_ACTIVE)
      data_n = 10'(x_n) + 10'(32'(y_n) * H_ACTIVE) + frame_count[9:0];
  end
`else
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar;
  logic       lit;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (32'(x_n) >= k * BAR_W) bar = 3'(k);
    // Bayer phase: even rows G,R,G,R...; odd rows B,G,B,G...
    if (!y_n[0]) lit = x_n[0] ? bar[0] : bar[1];
    else         lit = x_n[0] ? bar[1] : bar[2];
    data_n = ((state_n == ST_ACTIVE) && lit) ? 10'h3FF : 10'h000;
  end
`endif

  assign fval_n = (state_n == ST_HLEAD) || (state_n == ST_ACTIVE) ||
                  ((state_n == ST_HTAIL) && (y_n != Y_LAST));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pixclk      <= 1'b0;
      fval        <= 1'b0;
      lval        <= 1'b0;
      data        <= '0;
      frame_count <= '0;
    end else begin
      pixclk <= (state == ST_IDLE) ? 1'b0 : ~pixclk;
      if (tick) begin
        fval <= fval_n;
        lval <= (state_n == ST_ACTIVE);
        data <= data_n;
      end
      if (frame_done) frame_count <= frame_count + 32'd1;
    end
  end

  assign cam.oPIXCLK      = pixclk;
  assign cam.oFrame_Valid = fval;
  assign cam.oLine_Valid  = lval;
  assign cam.oCamera_Data = data;
  assign cam.oFrame_Count = frame_count;
  assign cam.oBusy        = (state != ST_IDLE);
endmodule

// File: tb/tb_camera_sensor_emulator.sv
// tb/tb_camera_sensor_emulator.sv - directed self-checking bench for camera_sensor_emulator
// Small frame (8x4, blanks 4/2); pixel expectations come from an independent bar/ramp model.
module tb_camera_sensor_emulator;
  localparam int HA = 8, VA = 4, HB = 4, VB = 2;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fc_exp = 0;

  camera_sensor_emulator_if bus ();

  camera_sensor_emulator #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .cam    (bus)
  );

  always #10 Clock = ~Clock;

  function automatic logic [9:0] exp_pix(input int x, input int y, input int f);
`ifdef CAMERA_EMU_RAMP_EN
    return 10'((x + y * HA + f) % 1024);
`else
    logic [2:0] b;
    logic       c;
    b = 3'(x / (HA / 8));
    if (y % 2 == 0) c = (x % 2 == 0) ? b[1] : b[0];
    else            c = (x % 2 == 0) ? b[2] : b[1];
    return c ? 10'h3FF : 10'h000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the next negedge at which oPIXCLK is high (one per pixel)
  task automatic next_pix();
    int g;
    g = 0;
    do begin
      @(negedge Clock);
      g++;
    end while (!bus.oPIXCLK && g < 4);
  endtask

  task automatic wait_lval(output int gap);
    gap = 0;
    while (!bus.oLine_Valid && gap < 200) begin
      gap++;
      next_pix();
    end
    chk("lval_timeout", {31'd0, bus.oLine_Valid}, 32'd1);
  endtask

  task automatic run_frame(input int drop_line, input int drop_x);
    int gap, g;
    g = 0;
    while (!bus.oFrame_Valid && g < 200) begin
      g++;
      next_pix();
    end
    chk("fval_rise", {31'd0, bus.oFrame_Valid}, 32'd1);
    for (int l = 0; l < VA; l++) begin
      wait_lval(gap);
      if (l > 0) chk("line_gap", gap, HB);
      for (int x = 0; x < HA; x++) begin
        chk("lval_on", {31'd0, bus.oLine_Valid}, 32'd1);
        chk("fval_line", {31'd0, bus.oFrame_Valid}, 32'd1);
        chk($sformatf("pix f%0d y%0d x%0d", fc_exp, l, x), {22'd0, bus.oCamera_Data},
            {22'd0, exp_pix(x, l, fc_exp)});
        if (l == drop_line && x == drop_x) bus.Enable = 1'b0;
        next_pix();
      end
      chk("lval_off", {31'd0, bus.oLine_Valid}, 32'd0);
      chk("data_blank", {22'd0, bus.oCamera_Data}, 32'd0);
      chk("fval_tail", {31'd0, bus.oFrame_Valid}, (l == VA - 1) ? 32'd0 : 32'd1);
    end
    fc_exp++;
    chk("frame_count", bus.oFrame_Count, fc_exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  {31'd0, bus.oBusy}, 32'd0);
    chk({tag, "_pclk"},  {31'd0, bus.oPIXCLK}, 32'd0);
    chk({tag, "_fval"},  {31'd0, bus.oFrame_Valid}, 32'd0);
    chk({tag, "_lval"},  {31'd0, bus.oLine_Valid}, 32'd0);
    chk({tag, "_data"},  {22'd0, bus.oCamera_Data}, 32'd0);
  endtask

  // stability and pixel-clock monitor
  logic       prev_f = 1'b0, prev_l = 1'b0, prev_p = 1'b0, prev_b = 1'b0;
  logic [9:0] prev_d = '0;
  always @(negedge Clock) begin
    if (Resetn) begin
      if (bus.oLine_Valid !== prev_l || bus.oCamera_Data !== prev_d || bus.oFrame_Valid !== prev_f) begin
        checks++;
        assert (bus.oPIXCLK === 1'b0) else begin
          errors++;
          $error("FAIL stability observed_pclk=%0b expected_pclk=0", bus.oPIXCLK);
        end
      end
      if (prev_b && bus.oBusy) begin
        checks++;
        assert (bus.oPIXCLK !== prev_p) else begin
          errors++;
          $error("FAIL pclk_toggle observed=%0b expected=%0b", bus.oPIXCLK, ~prev_p);
        end
      end
    end
    prev_f <= bus.oFrame_Valid;
    prev_l <= bus.oLine_Valid;
    prev_d <= bus.oCamera_Data;
    prev_p <= bus.oPIXCLK;
    prev_b <= bus.oBusy;
  end

  initial begin
    int n, g;
    bus.Enable = 1'b0;
    repeat (3) @(negedge Clock);
    chk_idle("rst");
    chk("rst_count", bus.oFrame_Count, 32'd0);
    Resetn = 1'b1;
    repeat (5) @(negedge Clock);
    chk_idle("post_rst");

    // FVAL rises V_BLANK*(HA+HB) pixels after leaving IDLE
    bus.Enable = 1'b1;
    @(posedge Clock);
    n = 0;
    forever begin
      @(negedge Clock);
      if (bus.oFrame_Valid || n >= 200) break;
      n++;
    end
    chk("fval_delay_clks", n, 2 * VB * (HA + HB));

    // Enable dropped at pixel 3 of line 1: frame completes, then IDLE
    run_frame(1, 3);
    repeat (12) @(negedge Clock);
    chk_idle("drop");
    chk("drop_count", bus.oFrame_Count, 32'd1);
    repeat (10) @(negedge Clock);
    chk("stay_idle", {31'd0, bus.oBusy}, 32'd0);

    // asynchronous reset in ACTIVE
    bus.Enable = 1'b1;
    g = 0;
    while (!bus.oLine_Valid && g < 200) begin
      g++;
      next_pix();
    end
    chk("reach_active", {31'd0, bus.oLine_Valid}, 32'd1);
    Resetn = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_count", bus.oFrame_Count, 32'd0);
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    fc_exp = 0;

    // three clean back-to-back frames
    run_frame(-1, -1);
    run_frame(-1, -1);
    run_frame(-1, -1);
    chk("count_after3", bus.oFrame_Count, 32'd3);

    // Enable dropped during V_BLANK returns to IDLE at the next pixel boundary
    repeat (4) next_pix();
    chk("in_vblank_busy", {31'd0, bus.oBusy}, 32'd1);
    chk("in_vblank_fval", {31'd0, bus.oFrame_Valid}, 32'd0);
    bus.Enable = 1'b0;
    repeat (2) @(negedge Clock);
    chk_idle("vblank_drop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
